i2c_write_sequencer: RTL and testbench
======================================

I2C_WRITE_SEQUENCER -- requirements
Module: i2c_write_sequencer

Interface
REQ-001 Parameter LEN_W, default 4: width of the byte-count input, giving a maximum of 2^LEN_W-1 data bytes per transaction.
REQ-002 i_clk  in  1  single system clock; all logic SHALL be rising-edge.
REQ-003 i_rst_n  in  1  synchronous, active-low reset.
REQ-004 i_tick  in  1  quarter-SCL-period strobe; also routed to the byte controller.
REQ-005 i_req  in  1  transaction request; accepted only in IDLE.
REQ-006 i_addr  in  7  7-bit slave address; the sequencer appends W bit 0.
REQ-007 i_len  in  LEN_W  number of data bytes; 0 means an address-only probe.
REQ-008 i_wr_data  in  8  show-ahead write data, consumed on o_data_pop.
REQ-009 o_data_pop  out  1  one-cycle pulse; i_wr_data is captured in that cycle.
REQ-010 o_byte_start, o_byte_data[8]  out  launch pulse and byte to the I2C TX byte controller.
REQ-011 i_byte_done, i_byte_error  in  1 each  byte result from the controller: ACK or NACK.
REQ-012 i_byte_sda, i_byte_scl, i_byte_sda_dis, i_byte_scl_dis  in  1 each  controller bus drive.
REQ-013 i_scl  in  1  sampled SCL line, used for stretch detection.
REQ-014 o_sda, o_scl, o_sda_disable, o_scl_disable  out  1 each  muxed bus drive; disable=1 releases the line.
REQ-015 o_busy, o_done, o_nack  out  1 each  status outputs; o_done is a one-cycle pulse, and o_nack is valid with o_done.

Function
REQ-016 States: IDLE, START, ADDR, ADDR_WAIT, DATA, DATA_WAIT, STOP, DONE.
REQ-017 IDLE: when i_req=1, latch i_addr and i_len, set o_busy=1, clear o_nack, and go to START; otherwise hold the bus released.
REQ-018 START, advancing one step per i_tick: step 0 drives SDA=1, SCL=1; step 1 waits while i_scl=0 (stretch); step 2 drives SDA=0; step 3 drives SCL=0 and goes to ADDR.
REQ-019 ADDR: pulse o_byte_start for one cycle with o_byte_data={addr,1'b0}, then go to ADDR_WAIT.
REQ-020 In any *_WAIT state, i_byte_done/i_byte_error SHALL be ignored in the cycle after o_byte_start; the first subsequent high cycle is the result.
REQ-021 ADDR_WAIT: on error set o_nack=1 and go to STOP; on done go to DATA if len>0, else go to STOP.
REQ-022 DATA: assert o_data_pop and o_byte_start in the same cycle, register o_byte_data=i_wr_data, decrement the remaining count, and go to DATA_WAIT.
REQ-023 DATA_WAIT: on error set o_nack=1 and go to STOP, with no further pops; on done go to DATA if remaining>0, else go to STOP.
REQ-024 STOP, one step per i_tick: step 0 drives SDA=0, SCL=0; step 1 drives SCL=1; step 2 waits while i_scl=0; step 3 drives SDA=1 and goes to DONE.
REQ-025 DONE: pulse o_done for one cycle, drop o_busy, and go to IDLE.
REQ-026 Bus mux: in ADDR/ADDR_WAIT/DATA/DATA_WAIT the o_sda/o_scl/disable outputs SHALL pass through i_byte_*; in START/STOP the sequencer drives both lines (disables=0); in IDLE/DONE both disables=1.
REQ-027 i_req while o_busy=1 SHALL be ignored, with no queuing.
REQ-028 Exactly i_len pops per successful transaction, and fewer only after a NACK; never more.
REQ-029 A simultaneous done and error SHALL be treated as error.
REQ-030 The remaining counter SHALL be LEN_W bits and never wrap; the last byte is the one at which remaining=1 before decrement.

Reset
REQ-031 While i_rst_n=0: state=IDLE, o_busy=0, o_done=0, o_nack=0, o_data_pop=0, o_byte_start=0, o_byte_data=0, o_sda=1, o_scl=1, o_sda_disable=1, o_scl_disable=1, and all counters 0.
REQ-032 Reset asserted mid-transaction SHALL release the bus in the next cycle, with no STOP generated and no o_done.

Structure
REQ-033 State encodings and the START/STOP step constants SHALL live in the shared package i2c_pkg.
REQ-034 The START/STOP condition generator SHALL be one sub-module, i2c_cond_gen (inputs: tick, go, is_stop, i_scl; output: done), instantiated once.
REQ-035 The byte controller SHALL remain external to this block.

Verification
REQ-036 i_addr=0x50, i_len=2, data 0xA5, 0x3C, with an ACK model: the byte controller sees 0xA0, 0xA5, 0x3C; two pops; o_done=1 with o_nack=0.
REQ-037 Address NACK on i_addr=0x21, i_len=3: the byte controller sees 0x42 only; zero pops; STOP is generated; o_done=1 with o_nack=1.
REQ-038 Data NACK on byte 2 of i_len=4: two pops, STOP, o_nack=1, and no third o_byte_start.
REQ-039 i_len=0 probe: address only; SDA rises while SCL=1 at STOP; o_done is asserted.
REQ-040 Hold i_scl low for 10 ticks in START step 1: SDA stays 1 until i_scl rises, then the sequence resumes.
REQ-041 Drop i_rst_n during DATA_WAIT: the next cycle has both disables=1, o_busy=0, and no o_done pulse.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write sequencer: FSM states and the
// START/STOP step numbering with the line levels driven at each step.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_WAIT,
    ST_DATA,
    ST_DATA_WAIT,
    ST_STOP,
    ST_DONE
  } seq_state_e;

  // Condition generator steps, one per quarter-SCL tick.
  localparam logic [1:0] STEP_FIRST      = 2'd0;
  localparam logic [1:0] START_WAIT_STEP = 2'd1;  // START: wait for SCL high
  localparam logic [1:0] STOP_WAIT_STEP  = 2'd2;  // STOP: wait for SCL high
  localparam logic [1:0] STEP_LAST       = 2'd3;

  // Line levels {sda, scl} driven during each step of a START or STOP.
  function automatic logic [1:0] cond_drive(input logic is_stop, input logic [1:0] step);
    logic [1:0] lv;
    lv = 2'b11;
    if (!is_stop) begin
      case (step)
        2'd0:    lv = 2'b11;
        2'd1:    lv = 2'b11;
        2'd2:    lv = 2'b01;  // SDA falls while SCL high
        default: lv = 2'b00;
      endcase
    end else begin
      case (step)
        2'd0:    lv = 2'b00;
        2'd1:    lv = 2'b01;
        2'd2:    lv = 2'b01;
        default: lv = 2'b11;  // SDA rises while SCL high
      endcase
    end
    return lv;
  endfunction

endpackage

// File: rtl/i2c_cond_gen.sv
// START/STOP condition generator: walks four tick-paced steps while go is
// held, stalls at the wait step while SCL is stretched low, and pulses done
// on the tick that finishes the last step.
module i2c_cond_gen
  import i2c_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_go,
  input  logic i_is_stop,
  input  logic i_scl,
  output logic o_done,
  output logic o_sda,
  output logic o_scl
);

  logic [1:0] step_q, step_d;
  logic       wait_step;
  logic       advance;

  // Step sequencing, stretch stall and line levels for the current step.
  always_comb begin
    wait_step = (step_q == (i_is_stop ? STOP_WAIT_STEP : START_WAIT_STEP));
    advance   = i_go && i_tick && !(wait_step && !i_scl);
    o_done    = advance && (step_q == STEP_LAST);
    step_d    = step_q;
    if (!i_go) begin
      step_d = STEP_FIRST;
    end else if (advance) begin
      step_d = step_q + 2'd1;  // last step wraps back to the first
    end
    {o_sda, o_scl} = cond_drive(i_is_stop, step_q);
  end

  // Step register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      step_q <= STEP_FIRST;
    end else begin
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/i2c_write_sequencer.sv
// I2C master write sequencer: START, address byte with W bit, i_len data
// bytes through an external byte controller, then STOP. Owns the bus in
// START/STOP, passes the byte controller through otherwise.
module i2c_write_sequencer
  import i2c_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_req,
  input  logic [6:0]       i_addr,
  input  logic [LEN_W-1:0] i_len,
  input  logic [7:0]       i_wr_data,
  output logic             o_data_pop,
  output logic             o_byte_start,
  output logic [7:0]       o_byte_data,
  input  logic             i_byte_done,
  input  logic             i_byte_error,
  input  logic             i_byte_sda,
  input  logic             i_byte_scl,
  input  logic             i_byte_sda_dis,
  input  logic             i_byte_scl_dis,
  input  logic             i_scl,
  output logic             o_sda,
  output logic             o_scl,
  output logic             o_sda_disable,
  output logic             o_scl_disable,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_nack
);

  seq_state_e       state_q, state_d;
  logic [6:0]       addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             nack_q, nack_d;
  logic             first_q, first_d;  // first WAIT cycle: controller result not yet valid
  logic [7:0]       byte_data_q, byte_data_d;
  logic             result_ok, result_err;
  logic             cond_go, cond_is_stop, cond_done, cond_sda, cond_scl;

  assign cond_go      = (state_q == ST_START) || (state_q == ST_STOP);
  assign cond_is_stop = (state_q == ST_STOP);
  assign o_byte_data  = byte_data_q;

  i2c_cond_gen u_cond_gen (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_tick    (i_tick),
    .i_go      (cond_go),
    .i_is_stop (cond_is_stop),
    .i_scl     (i_scl),
    .o_done    (cond_done),
    .o_sda     (cond_sda),
    .o_scl     (cond_scl)
  );

  // Next-state logic and outputs; error wins over done, first WAIT cycle ignored.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    nack_d      = nack_q;
    byte_data_d = byte_data_q;
    first_d     = (state_q == ST_ADDR) || (state_q == ST_DATA);
    result_err  = !first_q && i_byte_error;
    result_ok   = !first_q && i_byte_done && !i_byte_error;

    o_busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    o_done        = (state_q == ST_DONE);
    o_nack        = nack_q;
    o_data_pop    = (state_q == ST_DATA);
    o_byte_start  = (state_q == ST_ADDR) || (state_q == ST_DATA);
    o_sda         = 1'b1;
    o_scl         = 1'b1;
    o_sda_disable = 1'b1;
    o_scl_disable = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          addr_d  = i_addr;
          rem_d   = i_len;
          nack_d  = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cond_done) begin
          byte_data_d = {addr_q, 1'b0};
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_ADDR_WAIT;
      ST_ADDR_WAIT, ST_DATA_WAIT: begin
        if (result_err) begin
          nack_d  = 1'b1;
          state_d = ST_STOP;
        end else if (result_ok) begin
          if (rem_q != '0) begin
            // Show-ahead head is already valid, so the byte is on the
            // output in the same cycle as the launch pulse.
            byte_data_d = i_wr_data;
            state_d     = ST_DATA;
          end else begin
            state_d = ST_STOP;
          end
        end
      end
      ST_DATA: begin
        byte_data_d = i_wr_data;  // head is unchanged until the pop edge
        if (rem_q != '0) begin
          rem_d = rem_q - LEN_W'(1);
        end
        state_d = ST_DATA_WAIT;
      end
      ST_STOP: begin
        if (cond_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_START) || (state_q == ST_STOP)) begin
      o_sda         = cond_sda;
      o_scl         = cond_scl;
      o_sda_disable = 1'b0;
      o_scl_disable = 1'b0;
    end else if ((state_q == ST_ADDR) || (state_q == ST_ADDR_WAIT) ||
                 (state_q == ST_DATA) || (state_q == ST_DATA_WAIT)) begin
      o_sda         = i_byte_sda;
      o_scl         = i_byte_scl;
      o_sda_disable = i_byte_sda_dis;
      o_scl_disable = i_byte_scl_dis;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      nack_q      <= 1'b0;
      first_q     <= 1'b0;
      byte_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      nack_q      <= nack_d;
      first_q     <= first_d;
      byte_data_q <= byte_data_d;
    end
  end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Directed bench for i2c_write_sequencer with a byte-controller model,
// a show-ahead data FIFO model and a scoreboard of expected bytes.
module tb_i2c_write_sequencer;
  localparam int LEN_W = 4;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_tick = 1'b0;
  logic             i_req = 1'b0;
  logic [6:0]       i_addr = '0;
  logic [LEN_W-1:0] i_len = '0;
  logic [7:0]       i_wr_data = '0;
  logic             o_data_pop, o_byte_start;
  logic [7:0]       o_byte_data;
  logic             i_byte_done = 1'b0, i_byte_error = 1'b0;
  logic             i_byte_sda = 1'b0, i_byte_scl = 1'b0;
  logic             i_byte_sda_dis = 1'b1, i_byte_scl_dis = 1'b0;
  logic             i_scl;
  logic             o_sda, o_scl, o_sda_disable, o_scl_disable;
  logic             o_busy, o_done, o_nack;

  int compared = 0, mismatched = 0;
  bit scl_stretch = 1'b0;

  logic [7:0] exp_bytes[$];
  logic [7:0] data_fifo[$];

  int nack_at = -1, resp_delay = 3, resp_cnt = 0, byte_idx = 0, byte_cnt = 0;
  bit resp_nack = 0, both_on_nack = 0, glitch_next = 0, model_busy = 0;
  int pops = 0, done_cnt = 0, start_cnt = 0, stop_cnt = 0;
  bit last_nack = 0;
  int exp_pops = 0;
  bit exp_nack = 0;
  int base_pops, base_done, base_start, base_stop, base_bytes;
  logic prev_sda = 1'b1, prev_scl = 1'b1, sda_l, scl_l;
  int tick_div = 0;

  assign i_scl = scl_stretch ? 1'b0 : (o_scl_disable ? 1'b1 : o_scl);

  i2c_write_sequencer #(.LEN_W(LEN_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_req(i_req),
    .i_addr(i_addr), .i_len(i_len), .i_wr_data(i_wr_data),
    .o_data_pop(o_data_pop), .o_byte_start(o_byte_start), .o_byte_data(o_byte_data),
    .i_byte_done(i_byte_done), .i_byte_error(i_byte_error),
    .i_byte_sda(i_byte_sda), .i_byte_scl(i_byte_scl),
    .i_byte_sda_dis(i_byte_sda_dis), .i_byte_scl_dis(i_byte_scl_dis),
    .i_scl(i_scl), .o_sda(o_sda), .o_scl(o_scl),
    .o_sda_disable(o_sda_disable), .o_scl_disable(o_scl_disable),
    .o_busy(o_busy), .o_done(o_done), .o_nack(o_nack)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Quarter-period tick every fourth cycle.
  always @(negedge i_clk) begin
    tick_div = (tick_div + 1) % 4;
    i_tick = (tick_div == 0);
  end

  // Byte controller model: checks each launched byte against the scoreboard,
  // drives a bogus done+error in the ignored cycle, then the real result.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      i_byte_done = 0; i_byte_error = 0; resp_cnt = 0;
      glitch_next = 0; model_busy = 0;
    end else begin
      i_byte_done = 0; i_byte_error = 0;
      if (glitch_next) begin
        glitch_next = 0;
        i_byte_done = 1; i_byte_error = 1;
        check("passthrough", {o_busy, o_sda, o_scl, o_sda_disable, o_scl_disable},
              {1'b1, i_byte_sda, i_byte_scl, i_byte_sda_dis, i_byte_scl_dis});
      end
      if (resp_cnt != 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          model_busy = 0;
          i_byte_error = resp_nack;
          i_byte_done = !resp_nack || both_on_nack;
        end
      end
      if (o_byte_start) begin
        byte_cnt++;
        check("start_while_busy", model_busy, 0);
        compared++;
        assert (exp_bytes.size() != 0) else begin
          mismatched++;
          $error("FAIL unexpected_byte: observed=0x%0h expected=no launch", o_byte_data);
        end
        if (exp_bytes.size() != 0) check("byte_data", o_byte_data, exp_bytes.pop_front());
        resp_nack = (byte_idx == nack_at);
        byte_idx++;
        resp_cnt = resp_delay;
        model_busy = 1;
        glitch_next = 1;
      end
    end
  end

  // Show-ahead FIFO: head advances after each pop.
  always @(negedge i_clk) begin
    if (i_rst_n && o_data_pop) begin
      pops++;
      check("pop_with_start", o_byte_start, 1);
      if (data_fifo.size() != 0) void'(data_fifo.pop_front());
      i_wr_data = (data_fifo.size() != 0) ? data_fifo[0] : 8'h00;
    end
  end

  // Done pulses and START/STOP conditions on the driven lines.
  always @(negedge i_clk) begin
    sda_l = o_sda_disable | o_sda;
    scl_l = o_scl_disable | o_scl;
    if (o_done === 1'b1) begin done_cnt++; last_nack = o_nack; end
    if (prev_scl && scl_l && prev_sda && !sda_l) start_cnt++;
    if (prev_scl && scl_l && !prev_sda && sda_l) stop_cnt++;
    prev_sda = sda_l; prev_scl = scl_l;
  end

  task automatic launch(input logic [6:0] addr, input int len, input int nack,
                        input bit both, input int delay);
    int sent;
    sent = (nack < 0) ? len : nack;
    exp_bytes.delete();
    exp_bytes.push_back({addr, 1'b0});
    for (int i = 0; i < sent; i++) exp_bytes.push_back(data_fifo[i]);
    exp_pops = sent; exp_nack = (nack >= 0);
    nack_at = nack; both_on_nack = both; resp_delay = delay; byte_idx = 0;
    base_pops = pops; base_done = done_cnt; base_start = start_cnt;
    base_stop = stop_cnt; base_bytes = byte_cnt;
    i_wr_data = (data_fifo.size() != 0) ? data_fifo[0] : 8'h00;
    @(negedge i_clk);
    i_req = 1; i_addr = addr; i_len = LEN_W'(len);
    @(negedge i_clk);
    i_req = 0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == base_done && n < 4000) begin @(negedge i_clk); #1; n++; end
    compared++;
    assert (done_cnt != base_done) else begin
      mismatched++;
      $error("FAIL %s_timeout: observed=no o_done expected=o_done within 4000 cycles", tag);
    end
    repeat (20) @(negedge i_clk);
    #1;
  endtask

  task automatic check_txn(input string tag);
    check({tag, "_done_pulses"}, done_cnt - base_done, 1);
    check({tag, "_nack"}, last_nack, exp_nack);
    check({tag, "_pops"}, pops - base_pops, exp_pops);
    check({tag, "_bytes_missing"}, exp_bytes.size(), 0);
    check({tag, "_start_cond"}, start_cnt - base_start, 1);
    check({tag, "_stop_cond"}, stop_cnt - base_stop, 1);
    check({tag, "_busy_after"}, o_busy, 0);
    $display("txn %s: bytes=%0d pops=%0d nack=%0b done=%0d", tag,
             byte_cnt - base_bytes, pops - base_pops, last_nack, done_cnt - base_done);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge i_clk);
    check("rst_status", {o_busy, o_done, o_nack, o_data_pop, o_byte_start}, 5'b00000);
    check("rst_byte_data", o_byte_data, 8'h00);
    check("rst_bus", {o_sda, o_scl, o_sda_disable, o_scl_disable}, 4'hF);
    i_rst_n = 1;
    repeat (4) @(negedge i_clk);

    // Two-byte write, all ACK.
    data_fifo = '{8'hA5, 8'h3C};
    launch(7'h50, 2, -1, 0, 6);
    wait_done("ack2");
    check_txn("ack2");

    // Address NACK, with done and error raised together.
    data_fifo = '{8'h01, 8'h02, 8'h03};
    launch(7'h21, 3, 0, 1, 5);
    wait_done("addr_nack");
    check_txn("addr_nack");

    // NACK on the second data byte of four.
    data_fifo = '{8'h11, 8'h22, 8'h33, 8'h44};
    launch(7'h13, 4, 2, 0, 4);
    wait_done("data_nack");
    check_txn("data_nack");
    check("data_nack_fifo_left", data_fifo.size(), 2);

    // Address-only probe, with a request arriving while busy.
    data_fifo.delete();
    launch(7'h7F, 0, -1, 0, 5);
    repeat (2) @(negedge i_clk);
    i_req = 1; i_addr = 7'h01; i_len = LEN_W'(1);
    @(negedge i_clk);
    i_req = 0;
    wait_done("probe");
    check_txn("probe");
    repeat (300) @(negedge i_clk);
    check("probe_no_queued_req", done_cnt - base_done, 1);
    check("probe_idle_busy", o_busy, 0);

    // SCL held low during the START wait step for ten ticks.
    data_fifo = '{8'h5A};
    scl_stretch = 1;
    launch(7'h0A, 1, -1, 0, 5);
    repeat (40) @(negedge i_clk);
    #1;
    check("stretch_hold_bus", {o_busy, o_sda_disable, o_sda, o_scl}, 4'b1011);
    check("stretch_no_start_cond", start_cnt - base_start, 0);
    check("stretch_no_byte", byte_cnt - base_bytes, 0);
    scl_stretch = 0;
    wait_done("stretch");
    check_txn("stretch");

    // Reset during the first DATA_WAIT.
    data_fifo = '{8'h01, 8'h02, 8'h03};
    launch(7'h33, 3, -1, 0, 40);
    n = 0;
    while (pops == base_pops && n < 2000) begin @(negedge i_clk); #1; n++; end
    check("rst_mid_reached_data", pops - base_pops, 1);
    @(negedge i_clk);
    i_rst_n = 0;
    @(negedge i_clk);
    #1;
    check("rst_mid_release", {o_sda_disable, o_scl_disable, o_busy, o_done}, 4'b1100);
    repeat (5) @(negedge i_clk);
    #1;
    check("rst_mid_no_done", done_cnt - base_done, 0);
    check("rst_mid_no_stop", stop_cnt - base_stop, 0);
    $display("txn rst_mid: bytes=%0d pops=%0d aborted", byte_cnt - base_bytes, pops - base_pops);
    i_rst_n = 1;
    exp_bytes.delete();
    repeat (4) @(negedge i_clk);

    // Normal operation after the abort.
    data_fifo = '{8'hC3};
    launch(7'h44, 1, -1, 0, 3);
    wait_done("after_rst");
    check_txn("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
